// File: rtl/arb_pkg.sv
// Shared definitions for the priority / round-robin arbiter.
package arb_pkg;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } arb_state_e;

    // $clog2 that never returns less than one bit, so every derived width stays legal.
    function automatic int unsigned clog2_min1(input int unsigned value);
        return (value <= 2) ? 1 : $clog2(value);
    endfunction

endpackage

// File: rtl/prio_enc_param.sv
// Combinational highest-set-index priority encoder with a valid flag.
module prio_enc_param
    import arb_pkg::*;
#(
    parameter  int unsigned N = 8,
    localparam int unsigned W = clog2_min1(N)
) (
    input  logic [N-1:0] vec,
    output logic [W-1:0] idx,
    output logic         valid
);

    // Scan upward so the highest set bit is the last one to write idx.
    always_comb begin
        idx   = '0;
        valid = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (vec[i]) begin
                idx   = W'(i);
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/priority_arbiter_rr.sv
// Registered N-requester arbiter with fixed or round-robin priority and a hold-time limit.
module priority_arbiter_rr
    import arb_pkg::*;
#(
    parameter  int unsigned N        = 8,
    parameter  int unsigned MAX_HOLD = 16,
    localparam int unsigned W        = clog2_min1(N)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req,
    input  logic         mode,
    input  logic         done,
    output logic         gnt_valid,
    output logic [W-1:0] gnt_idx,
    output logic [N-1:0] gnt_onehot,
    output logic         timeout
);

    localparam int unsigned HW = clog2_min1(MAX_HOLD + 1);
    // With no limit the counter simply parks at zero.
    localparam logic [HW-1:0] HOLD_LAST = (MAX_HOLD == 0) ? '0 : HW'(MAX_HOLD - 1);
    localparam logic [W-1:0]  LAST_IDX  = W'(N - 1);

    arb_state_e    state_q, state_d;
    logic          gnt_valid_q, gnt_valid_d;
    logic [W-1:0]  gnt_idx_q, gnt_idx_d;
    logic [N-1:0]  gnt_onehot_q, gnt_onehot_d;
    logic          timeout_q, timeout_d;
    logic [W-1:0]  rr_ptr_q, rr_ptr_d;
    logic [HW-1:0] hold_cnt_q, hold_cnt_d;

    logic          owner_req;
    logic          limit_hit;
    logic          release_grant;
    logic          revoke;
    logic          arbitrate;
    logic          take_grant;
    logic [N-1:0]  arb_req;
    logic [W-1:0]  rot;
    logic [N-1:0]  rotated;
    logic [W-1:0]  enc_idx;
    logic          enc_valid;
    logic [W-1:0]  winner;

    // Release detection and the masked request vector used for handover.
    always_comb begin
        owner_req     = req[gnt_idx_q];
        limit_hit     = (MAX_HOLD != 0) && (hold_cnt_q == HOLD_LAST);
        release_grant = (state_q == ST_GRANT) && (done || !owner_req || limit_hit);
        // done wins over the limit; a dropped request is a plain release, not a revoke.
        revoke        = release_grant && limit_hit && !done && owner_req;
        arbitrate     = (state_q == ST_IDLE) || release_grant;
        // The releasing owner sits out the immediate handover only.
        arb_req       = release_grant ? (req & ~gnt_onehot_q) : req;
        rot           = (mode == MODE_RR) ? (LAST_IDX - rr_ptr_q) : '0;
    end

    // Rotate so rr_ptr lands on the top bit; the encoder then searches downward from it.
    always_comb begin
        rotated = '0;
        for (int k = 0; k < N; k++) begin
            int unsigned src;
            src = k + N - int'(rot);
            if (src >= N) begin
                src = src - N;
            end
            rotated[k] = arb_req[W'(src)];
        end
    end

    prio_enc_param #(
        .N(N)
    ) u_enc (
        .vec  (rotated),
        .idx  (enc_idx),
        .valid(enc_valid)
    );

    // Undo the rotation to recover the real requester index.
    always_comb begin
        int unsigned w;
        w = int'(enc_idx) + N - int'(rot);
        if (w >= N) begin
            w = w - N;
        end
        winner     = W'(w);
        take_grant = arbitrate && enc_valid;
    end

    // State register plus all registered outputs and bookkeeping.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            gnt_valid_q  <= 1'b0;
            gnt_idx_q    <= '0;
            gnt_onehot_q <= '0;
            timeout_q    <= 1'b0;
            rr_ptr_q     <= LAST_IDX;
            hold_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            gnt_valid_q  <= gnt_valid_d;
            gnt_idx_q    <= gnt_idx_d;
            gnt_onehot_q <= gnt_onehot_d;
            timeout_q    <= timeout_d;
            rr_ptr_q     <= rr_ptr_d;
            hold_cnt_q   <= hold_cnt_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:  if (enc_valid) state_d = ST_GRANT;
            ST_GRANT: if (release_grant && !enc_valid) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Next values for the grant outputs, rr_ptr and hold counter.
    always_comb begin
        gnt_valid_d  = gnt_valid_q;
        gnt_idx_d    = gnt_idx_q;
        gnt_onehot_d = gnt_onehot_q;
        timeout_d    = revoke;
        rr_ptr_d     = rr_ptr_q;
        hold_cnt_d   = hold_cnt_q;
        if (take_grant) begin
            gnt_valid_d  = 1'b1;
            gnt_idx_d    = winner;
            gnt_onehot_d = N'(1) << winner;
            hold_cnt_d   = '0;
            if (mode == MODE_RR) begin
                rr_ptr_d = (winner == '0) ? LAST_IDX : (winner - W'(1));
            end
        end else if (release_grant) begin
            gnt_valid_d  = 1'b0;
            gnt_idx_d    = '0;
            gnt_onehot_d = '0;
            hold_cnt_d   = '0;
        end else if ((state_q == ST_GRANT) && (hold_cnt_q != HOLD_LAST)) begin
            hold_cnt_d = hold_cnt_q + HW'(1);
        end
    end

    assign gnt_valid  = gnt_valid_q;
    assign gnt_idx    = gnt_idx_q;
    assign gnt_onehot = gnt_onehot_q;
    assign timeout    = timeout_q;

endmodule
